period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures the interval between successive rising edges of an external event line, in whole milliseconds of a 100 MHz clock.
- Reports each interval with a one-cycle valid strobe and an overflow flag.
- Complements the ms-period tick generator: the generator produces periodic events, this block recovers their period for display, checking and closed-loop timing.

Parameters:
- CLK_PER_MS, 100000: clocks per millisecond; prescaler wraps at CLK_PER_MS-1.
- MS_WIDTH, 16: width of the millisecond counter and of the period result.
- SYNC_STAGES, 2: flip-flop stages in the event_in synchronizer, minimum 2.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  high = measure; low = abort and idle.
- event_in  input  1  asynchronous event line; rising edges are measured.
- period_ms  output  MS_WIDTH  last measured interval in ms, held until the next result.
- valid  output  1  one-cycle strobe when period_ms/overflow update.
- overflow  output  1  last interval exceeded 2^MS_WIDTH-1 ms; held with period_ms.
- busy  output  1  high in state MEASURE.

Behaviour:
- Reset (async, any time): state IDLE, synchronizer/edge register 0, prescaler 0, ms counter 0, sticky ovf 0; period_ms 0, valid 0, overflow 0, busy 0. Reset mid-measurement discards the interval; no valid.
- Synchronizer: event_in passes through SYNC_STAGES FFs, then one delay FF. rise = sync_out & ~delayed, one cycle per edge. Latency: rise asserts SYNC_STAGES clocks after the first clk edge sampling event_in high. Pulses shorter than one clock may be missed.
- State IDLE:
  - prescaler and ms counter held at 0; busy 0.
  - rise with enable=1 -> MEASURE; counters cleared; no valid.
- State MEASURE:
  - prescaler increments each clock; at CLK_PER_MS-1 it wraps to 0 and the ms counter increments.
  - ms counter saturates at 2^MS_WIDTH-1; an increment attempted at saturation sets sticky ovf.
- Capture on rise in MEASURE, registered in that clock:
  - period_ms <= ms counter, plus 1 if a prescaler wrap coincides, saturating. A coincident increment that would pass saturation also sets overflow.
  - overflow <= ovf or the coincident-saturation condition; valid <= 1 for exactly one cycle.
  - prescaler, ms counter and ovf cleared; state stays MEASURE, so consecutive edges give back-to-back results.
- Result definition: N = clocks between two successive rise pulses. period_ms = min(floor(N/CLK_PER_MS), 2^MS_WIDTH-1); overflow=1 iff floor(N/CLK_PER_MS) > 2^MS_WIDTH-1.
- enable low:
  - state -> IDLE next clock; counters and ovf cleared; no valid.
  - period_ms/overflow hold their last values.
  - enable low has priority over a simultaneous rise.
  - The first rise after enable returns high only arms measurement.
- period_ms/overflow change only on valid cycles or reset.

Test Plan:
1. CLK_PER_MS=10. Assert rst mid-stream, event_in toggling -> all outputs 0 immediately (async), state IDLE; after release, first rise -> busy=1, valid=0.
2. CLK_PER_MS=10. Rises N=35 clocks apart -> valid one cycle, period_ms=3, overflow=0. Further rises 29 apart -> 2; 30 apart (coincident wrap) -> 3; 9 apart -> 0.
3. CLK_PER_MS=10, MS_WIDTH=4. Rises 200 clocks apart -> period_ms=15, overflow=1. Next interval of 50 -> period_ms=5, overflow=0. Also 160 apart (coincident wrap at saturation) -> period_ms=15, overflow=1.
4. CLK_PER_MS=10. Drop enable 20 clocks into a measurement; rise while enable=0 -> no valid, busy=0, period_ms unchanged. Re-enable: first rise arms only; next rise 40 clocks later -> period_ms=4.
5. CLK_PER_MS=10. event_in raised asynchronously mid-cycle -> rise exactly SYNC_STAGES clocks after the sampling edge. Event held high 100 clocks -> a single rise; valid only on rising edges.

Source files
------------

// File: rtl/period_meter.sv
// period_meter: measures the interval between rising edges of an asynchronous
// event line in whole milliseconds, with a one-cycle valid strobe and overflow flag.
module period_meter #(
    parameter int CLK_PER_MS  = 100000,
    parameter int MS_WIDTH    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                event_in,
    output logic [MS_WIDTH-1:0] period_ms,
    output logic                valid,
    output logic                overflow,
    output logic                busy
);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_MS - 1);
    localparam logic [MS_WIDTH-1:0] MS_MAX = '1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MEAS = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic [0:0]             r_state;
    logic [PW-1:0]          r_pre;
    logic [MS_WIDTH-1:0]    r_ms;
    logic                   r_ovf;
    logic [MS_WIDTH-1:0]    r_period;
    logic                   r_valid;
    logic                   r_overflow;
    logic                   w_rise;
    logic                   w_wrap;
    logic                   w_ms_sat;

    assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_dly;
    assign w_wrap    = r_pre == PRE_MAX;
    assign w_ms_sat  = r_ms == MS_MAX;
    assign period_ms = r_period;
    assign valid     = r_valid;
    assign overflow  = r_overflow;
    assign busy      = r_state == S_MEAS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], event_in};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pre      <= '0;
            r_ms       <= '0;
            r_ovf      <= 1'b0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // enable low wins over a coincident rise and discards the interval
            if (!enable) begin
                r_state <= S_IDLE;
                r_pre   <= '0;
                r_ms    <= '0;
                r_ovf   <= 1'b0;
            end else if (r_state == S_IDLE) begin
                r_pre <= '0;
                r_ms  <= '0;
                r_ovf <= 1'b0;
                if (w_rise)
                    r_state <= S_MEAS;
            end else if (w_rise) begin
                // a wrap in the capture cycle completes the final millisecond
                r_period   <= (w_wrap && !w_ms_sat) ? r_ms + 1'b1 : r_ms;
                r_overflow <= r_ovf | (w_wrap & w_ms_sat);
                r_valid    <= 1'b1;
                r_pre      <= '0;
                r_ms       <= '0;
                r_ovf      <= 1'b0;
            end else begin
                r_pre <= w_wrap ? '0 : r_pre + 1'b1;
                if (w_wrap && w_ms_sat)
                    r_ovf <= 1'b1;
                else if (w_wrap)
                    r_ms <= r_ms + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: drives event edges at known clock spacings and checks each
// reported interval against floor(N/CLK_PER_MS) with saturation and overflow.
module tb_period_meter;
    localparam int CPM   = 10;
    localparam int MSW   = 4;
    localparam int SS    = 2;
    localparam int MAXMS = (1 << MSW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           event_in;
    logic [MSW-1:0] period_ms;
    logic           valid;
    logic           overflow;
    logic           busy;

    period_meter #(.CLK_PER_MS(CPM), .MS_WIDTH(MSW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .event_in(event_in),
        .period_ms(period_ms), .valid(valid), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; logic [MSW-1:0] p; logic o;} exp_t;
    typedef struct {int len; logic [MSW-1:0] p; logic o;} vec_t;

    exp_t           q[$];
    vec_t           tab[11];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             prev_d = 0;
    bit             armed = 0;
    bit             pend = 0;
    logic [MSW-1:0] pend_p = '0;
    logic           pend_o = 1'b0;
    logic [MSW-1:0] last_p = '0;
    logic           last_o = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // every reported interval must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(valid), 32'(0));
            end else begin
                e = q.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("period_ms", 32'(period_ms), 32'(e.p));
                chk("overflow", 32'(overflow), 32'(e.o));
            end
        end
    end

    // reference: an edge seen while enabled closes the open interval (if any) and opens a new one
    task automatic note_rise(input int d);
        exp_t e;
        int   ms;
        if (enable) begin
            if (armed) begin
                ms    = (d - prev_d) / CPM;
                e.cyc = d + 1 + SS;
                if (pend) begin
                    e.p = pend_p;
                    e.o = pend_o;
                end else begin
                    e.p = MSW'((ms > MAXMS) ? MAXMS : ms);
                    e.o = ms > MAXMS;
                end
                q.push_back(e);
                last_p = e.p;
                last_o = e.o;
            end
            armed  = 1;
            prev_d = d;
        end
        pend = 0;
    endtask

    task automatic rise(input int len, input bit use_tab, input logic [MSW-1:0] tp, input logic to);
        int hold;
        event_in = 1'b1;
        note_rise(cyc);
        pend   = use_tab;
        pend_p = tp;
        pend_o = to;
        hold   = $urandom_range(1, len - 1);
        repeat (hold) @(negedge clk);
        event_in = 1'b0;
        repeat (len - hold) @(negedge clk);
    endtask

    initial begin
        tab = '{'{35, 4'd3, 1'b0}, '{29, 4'd2, 1'b0}, '{30, 4'd3, 1'b0}, '{9, 4'd0, 1'b0},
                '{200, 4'd15, 1'b1}, '{50, 4'd5, 1'b0}, '{160, 4'd15, 1'b1}, '{150, 4'd15, 1'b0},
                '{159, 4'd15, 1'b0}, '{10, 4'd1, 1'b0}, '{2, 4'd0, 1'b0}};
        rst = 1'b1; enable = 1'b1; event_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            event_in = ~event_in;
        end
        chk("rst_period", 32'(period_ms), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        event_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        foreach (tab[i]) rise(tab[i].len, 1'b1, tab[i].p, tab[i].o);
        rise(5, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) rise($urandom_range(2, 200), 1'b0, '0, 1'b0);
        rise(5, 1'b0, '0, 1'b0);

        // asynchronous reset in the middle of a measurement
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_period", 32'(period_ms), 0);
        chk("async_rst_overflow", 32'(overflow), 0);
        chk("async_rst_valid", 32'(valid), 0);
        chk("async_rst_busy", 32'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            event_in = ~event_in;
        end
        @(negedge clk);
        event_in = 1'b0;
        rst = 1'b0;
        armed = 0;
        repeat (3) @(negedge clk);
        rise(12, 1'b0, '0, 1'b0);
        chk("post_rst_busy", 32'(busy), 1);
        chk("post_rst_period", 32'(period_ms), 0);

        // enable dropped mid-measurement, edge while disabled, then re-arm
        rise(20, 1'b0, '0, 1'b0);
        enable = 1'b0;
        armed = 0;
        repeat (3) @(negedge clk);
        chk("disabled_busy", 32'(busy), 0);
        rise(15, 1'b0, '0, 1'b0);
        chk("disabled_busy2", 32'(busy), 0);
        chk("disabled_hold_period", 32'(period_ms), 32'(last_p));
        chk("disabled_hold_ovf", 32'(overflow), 32'(last_o));
        enable = 1'b1;
        repeat (5) @(negedge clk);
        rise(40, 1'b0, '0, 1'b0);
        chk("rearm_busy", 32'(busy), 1);
        rise(10, 1'b0, '0, 1'b0);
        chk("reenable_period", 32'(period_ms), 4);
        chk("reenable_ovf", 32'(overflow), 0);

        // enable falls in exactly the cycle the edge is processed
        event_in = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        armed = 0;
        repeat (5) @(negedge clk);
        event_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("priority_busy", 32'(busy), 0);
        chk("priority_period", 32'(period_ms), 4);

        // mid-cycle event edge held high for 100 clocks
        enable = 1'b1;
        repeat (3) @(negedge clk);
        rise(30, 1'b0, '0, 1'b0);
        @(posedge clk);
        #3 event_in = 1'b1;
        note_rise(cyc);
        repeat (100) @(negedge clk);
        event_in = 1'b0;
        chk("hold_busy", 32'(busy), 1);
        repeat (5) @(negedge clk);
        rise(7, 1'b0, '0, 1'b0);
        repeat (10) @(negedge clk);
        chk("missing_valid", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
